// File: rtl/gb_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_alu_pkg
//  Description : Shared ALU constants: datapath width, shift-amount width,
//                shift-kind encoding and a word sign-extension helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gb_alu_pkg;

    localparam int XLEN          = 64;
    localparam int SHAMT_W       = 7;
    localparam int WORD_W        = 32;
    localparam int WORD_SHAMT_W  = 5;

    // Stage split of the shift-amount bits: S1 handles the low bits,
    // S2 handles the remaining high bits.
    localparam int S1_STEPS      = 4;
    localparam int S2_STEPS      = SHAMT_W - S1_STEPS;

    // Shift-kind encoding carried on the arith select input.
    localparam logic c_sr_logical = 1'b0;
    localparam logic c_sr_arith   = 1'b1;

    // Sign-extend the low word of a full-width value.
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WORD_W){v[WORD_W-1]}}, v[WORD_W-1:0]};
    endfunction

endpackage : gb_alu_pkg
`default_nettype wire

// File: rtl/gb_alu_sr_step.sv
`default_nettype none
// ============================================================================
//  Module      : gb_alu_sr_step
//  Description : One conditional right-shift step by a constant SHIFT with
//                an explicit fill bit. Shifts of WIDTH or more produce an
//                all-fill word.
//  Revision    : 1.0  initial release
// ============================================================================
module gb_alu_sr_step #(
    parameter int WIDTH = 64,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    // A step at least as wide as the word replaces every bit with fill.
    if (SHIFT >= WIDTH) begin : g_full
        assign o_data = i_en ? {WIDTH{i_fill}} : i_data;
    end else begin : g_part
        assign o_data = i_en ? {{SHIFT{i_fill}}, i_data[WIDTH-1:SHIFT]} : i_data;
    end

endmodule : gb_alu_sr_step
`default_nettype wire

// File: rtl/gb_alu_srx.sv
`default_nettype none
// ============================================================================
//  Module      : gb_alu_srx
//  Description : Two-stage pipelined 64-bit right shifter (logical or
//                arithmetic) with valid/ready handshake on both sides.
//                S1 applies shift steps 1/2/4/8, S2 applies 16/32/64.
//                Optional build macro GB_ALU_SRX_WORD_EN adds i_word for a
//                32-bit shift whose result is sign-extended to 64 bits.
//  Revision    : 1.0  initial release
// ============================================================================
module gb_alu_srx
    import gb_alu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [XLEN-1:0]    i_base,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_arith,
`ifdef GB_ALU_SRX_WORD_EN
    input  logic               i_word,
`endif
    output logic               o_valid,
    input  logic               i_ready,
    output logic [XLEN-1:0]    o_sr
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [XLEN-1:0]       r_s1_data;
    logic                  r_s1_fill;
    logic [S2_STEPS-1:0]   r_s1_hi;
    logic                  r_o_valid;
    logic [XLEN-1:0]       r_o_sr;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_accept;

    assign w_s2_adv = !r_o_valid || i_ready;
    assign o_ready  = !r_s1_valid || w_s2_adv;
    assign w_accept = i_valid && o_ready;
    assign o_valid  = r_o_valid;
    assign o_sr     = r_o_sr;

    // ------------------------------------------------------------------
    // Operand preparation. In word mode the upper half is pre-filled so
    // the unchanged 64-bit datapath yields the correct low word.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    w_op;
    logic               w_fill;
    logic [SHAMT_W-1:0] w_shamt;

`ifdef GB_ALU_SRX_WORD_EN
    logic r_s1_word;

    // Select 64-bit or 32-bit operand, fill and shift amount.
    always_comb begin
        w_op    = i_base;
        w_fill  = (i_arith == c_sr_arith) && i_base[XLEN-1];
        w_shamt = i_shamt;
        if (i_word) begin
            w_fill  = (i_arith == c_sr_arith) && i_base[WORD_W-1];
            w_op    = {{(XLEN-WORD_W){w_fill}}, i_base[WORD_W-1:0]};
            w_shamt = {{(SHAMT_W-WORD_SHAMT_W){1'b0}}, i_shamt[WORD_SHAMT_W-1:0]};
        end
    end

    // Carry the word flag alongside S1 data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_word <= 1'b0;
        end else if (w_accept) begin
            r_s1_word <= i_word;
        end
    end
`else
    assign w_op    = i_base;
    assign w_fill  = (i_arith == c_sr_arith) && i_base[XLEN-1];
    assign w_shamt = i_shamt;
`endif

    // ------------------------------------------------------------------
    // S1 combinational shift: steps 1, 2, 4, 8
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_s1_d1, w_s1_d2, w_s1_d3, w_s1_d4;

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(1)) u_s1_step1 (
        .i_data (w_op),
        .i_en   (w_shamt[0]),
        .i_fill (w_fill),
        .o_data (w_s1_d1)
    );

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(2)) u_s1_step2 (
        .i_data (w_s1_d1),
        .i_en   (w_shamt[1]),
        .i_fill (w_fill),
        .o_data (w_s1_d2)
    );

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(4)) u_s1_step4 (
        .i_data (w_s1_d2),
        .i_en   (w_shamt[2]),
        .i_fill (w_fill),
        .o_data (w_s1_d3)
    );

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(8)) u_s1_step8 (
        .i_data (w_s1_d3),
        .i_en   (w_shamt[3]),
        .i_fill (w_fill),
        .o_data (w_s1_d4)
    );

    // S1 register: load on accept; valid updates whenever S1 may move.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_fill  <= 1'b0;
            r_s1_hi    <= '0;
        end else begin
            if (o_ready) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_data <= w_s1_d4;
                r_s1_fill <= w_fill;
                r_s1_hi   <= w_shamt[SHAMT_W-1:S1_STEPS];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational shift: steps 16, 32, 64
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_s2_d1, w_s2_d2, w_s2_d3;
    logic [XLEN-1:0] w_s2_result;

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(16)) u_s2_step16 (
        .i_data (r_s1_data),
        .i_en   (r_s1_hi[0]),
        .i_fill (r_s1_fill),
        .o_data (w_s2_d1)
    );

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(32)) u_s2_step32 (
        .i_data (w_s2_d1),
        .i_en   (r_s1_hi[1]),
        .i_fill (r_s1_fill),
        .o_data (w_s2_d2)
    );

    gb_alu_sr_step #(.WIDTH(XLEN), .SHIFT(64)) u_s2_step64 (
        .i_data (w_s2_d2),
        .i_en   (r_s1_hi[2]),
        .i_fill (r_s1_fill),
        .o_data (w_s2_d3)
    );

`ifdef GB_ALU_SRX_WORD_EN
    // Word results take their upper half from bit 31 of the result, which
    // differs from the fill when a negative word is shifted logically by 0.
    assign w_s2_result = r_s1_word ? sext_word(w_s2_d3) : w_s2_d3;
`else
    assign w_s2_result = w_s2_d3;
`endif

    // S2 / output register: advances when empty or when downstream takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_o_sr    <= '0;
        end else if (w_s2_adv) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o_sr <= w_s2_result;
            end
        end
    end

endmodule : gb_alu_srx
`default_nettype wire

// File: tb/tb_gb_alu_srx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_alu_srx
//  Description : Directed self-checking bench for gb_alu_srx. Honours
//                GB_ALU_SRX_WORD_EN to exercise the word-shift port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gb_alu_srx;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_base;
    logic [6:0]  i_shamt;
    logic        i_arith;
    logic        i_word;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_sr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    gb_alu_srx u_dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_base  (i_base),
        .i_shamt (i_shamt),
        .i_arith (i_arith),
`ifdef GB_ALU_SRX_WORD_EN
        .i_word  (i_word),
`endif
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sr    (o_sr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] b, input logic [6:0] s,
                         input logic a, input logic w);
        i_valid = v;
        i_base  = b;
        i_shamt = s;
        i_arith = a;
        i_word  = w;
    endtask

    // One isolated op: accepted at the first edge, result visible after two.
    task automatic single(input string tag, input logic [63:0] b, input logic [6:0] s,
                          input logic a, input logic w, input logic [63:0] exp);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        drive(1'b1, b, s, a, w);
        @(negedge i_clk);
        check({tag, " rdy"}, {63'd0, o_ready}, 64'd1);
        @(posedge i_clk); #1;
        drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
        @(negedge i_clk);
        check({tag, " lat1"}, {63'd0, o_valid}, 64'd0);
        @(negedge i_clk);
        check({tag, " vld"}, {63'd0, o_valid}, 64'd1);
        check({tag, " sr"}, o_sr, exp);
    endtask

    logic [63:0] bb_b [4];
    logic [6:0]  bb_s [4];
    logic        bb_a [4];
    logic [63:0] bb_e [4];
    int          idx;
    int          got;

    initial begin
        i_rst   = 1'b1;
        i_ready = 1'b0;
        drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst vld", {63'd0, o_valid}, 64'd0);
        check("rst sr", o_sr, 64'd0);
        check("rst rdy", {63'd0, o_ready}, 64'd1);

        // Isolated ops with fixed latency
        single("lsr4",     64'h8000_0000_0000_0000, 7'd4,   1'b0, 1'b0, 64'h0800_0000_0000_0000);
        single("asr4",     64'h8000_0000_0000_0000, 7'd4,   1'b1, 1'b0, 64'hF800_0000_0000_0000);
        single("asr64",    64'h8000_0000_0000_0000, 7'd64,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        single("asr127",   64'h8000_0000_0000_0000, 7'd127, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        single("lsr100",   64'hFFFF_FFFF_FFFF_FFFF, 7'd100, 1'b0, 1'b0, 64'h0000_0000_0000_0000);
        single("sh0",      64'h1234_5678_9ABC_DEF0, 7'd0,   1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0);
        single("asr1pos",  64'h7FFF_FFFF_FFFF_FFFF, 7'd1,   1'b1, 1'b0, 64'h3FFF_FFFF_FFFF_FFFF);

        // Back-to-back ops with downstream always ready
        bb_b[0] = 64'h8000_0000_0000_0000; bb_s[0] = 7'd63; bb_a[0] = 1'b0; bb_e[0] = 64'h0000_0000_0000_0001;
        bb_b[1] = 64'h8000_0000_0000_0000; bb_s[1] = 7'd63; bb_a[1] = 1'b1; bb_e[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        bb_b[2] = 64'h1234_5678_9ABC_DEF0; bb_s[2] = 7'd20; bb_a[2] = 1'b0; bb_e[2] = 64'h0000_0123_4567_89AB;
        bb_b[3] = 64'hF000_0000_0000_0000; bb_s[3] = 7'd36; bb_a[3] = 1'b1; bb_e[3] = 64'hFFFF_FFFF_FF00_0000;
        for (int c = 0; c < 7; c++) begin
            @(posedge i_clk); #1;
            i_ready = 1'b1;
            if (c < 4) drive(1'b1, bb_b[c], bb_s[c], bb_a[c], 1'b0);
            else       drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            if (c < 4) check("b2b rdy", {63'd0, o_ready}, 64'd1);
            if (c >= 2 && c < 6) begin
                check("b2b vld", {63'd0, o_valid}, 64'd1);
                check("b2b sr", o_sr, bb_e[c-2]);
            end
            if (c == 6) check("b2b idle", {63'd0, o_valid}, 64'd0);
        end

        // Stall: downstream blocked for 5 cycles with 3 ops offered
        bb_b[0] = 64'h1111_2222_3333_4444; bb_s[0] = 7'd4;  bb_a[0] = 1'b0; bb_e[0] = 64'h0111_1222_2333_3444;
        bb_b[1] = 64'h8000_0000_0000_0001; bb_s[1] = 7'd1;  bb_a[1] = 1'b1; bb_e[1] = 64'hC000_0000_0000_0000;
        bb_b[2] = 64'hDEAD_BEEF_0000_0000; bb_s[2] = 7'd32; bb_a[2] = 1'b0; bb_e[2] = 64'h0000_0000_DEAD_BEEF;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            i_ready = 1'b0;
            if (idx < 3) drive(1'b1, bb_b[idx], bb_s[idx], bb_a[idx], 1'b0);
            else         drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            if (c >= 2) begin
                check("stall rdy", {63'd0, o_ready}, 64'd0);
                check("stall vld", {63'd0, o_valid}, 64'd1);
                check("stall sr", o_sr, bb_e[0]);
            end
            if (i_valid && o_ready) idx++;
        end
        check("stall accepted", idx, 64'd2);
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(posedge i_clk); #1;
            i_ready = 1'b1;
            if (idx < 3) drive(1'b1, bb_b[idx], bb_s[idx], bb_a[idx], 1'b0);
            else         drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            if (o_valid) begin
                check("drain sr", o_sr, bb_e[got]);
                got++;
            end
            if (i_valid && o_ready) idx++;
        end
        check("drain count", got, 64'd3);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            check("drain no dup", {63'd0, o_valid}, 64'd0);
        end

        // Reset with two ops in flight
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        drive(1'b1, 64'hFFFF_0000_FFFF_0000, 7'd8, 1'b1, 1'b0);
        @(posedge i_clk); #1;
        drive(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 7'd4, 1'b0, 1'b0);
        @(posedge i_clk); #1;
        drive(1'b0, 64'd0, 7'd0, 1'b0, 1'b0);
        @(negedge i_clk);
        check("pre-rst vld", {63'd0, o_valid}, 64'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("midrst vld", {63'd0, o_valid}, 64'd0);
        check("midrst sr", o_sr, 64'd0);
        check("midrst rdy", {63'd0, o_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check("midrst stale", {63'd0, o_valid}, 64'd0);
        end

`ifdef GB_ALU_SRX_WORD_EN
        single("word asr4", 64'h0000_0000_8000_0010, 7'd4,  1'b1, 1'b1, 64'hFFFF_FFFF_F800_0001);
        single("word sh0",  64'hFFFF_FFFF_8000_0010, 7'd0,  1'b0, 1'b1, 64'hFFFF_FFFF_8000_0010);
        single("word lsr36",64'h1234_5678_8000_0010, 7'd36, 1'b0, 1'b1, 64'h0000_0000_0800_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gb_alu_srx
`default_nettype wire
